// File: rtl/rf_pkg.sv
// rf_pkg: shared widths and write-back entry type for the register-file write queue
// Exports DATA_W, ADDR_W, NUM_REGS and wb_entry_t {rd, data}
package rf_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;
    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/rf_write_queue_if.sv
// rf_write_queue_if: producer handshakes, register-file write port and forwarding lookups
// master: producers/decode side (drives valids, stall, lookup addresses)
// slave: rf_write_queue (drives readies, RegWrite/WriteRegister/WriteData, fwd, busy)
interface rf_write_queue_if #(
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int ADDR_W = rf_pkg::ADDR_W
);
    logic                 ld_valid;
    logic [ADDR_W-1:0]    ld_rd;
    logic [DATA_W-1:0]    ld_data;
    logic                 ld_ready;
    logic                 alu_valid;
    logic [ADDR_W-1:0]    alu_rd;
    logic [DATA_W-1:0]    alu_data;
    logic                 alu_ready;
    logic                 wb_stall;
    logic                 RegWrite;
    logic [ADDR_W-1:0]    WriteRegister;
    logic [DATA_W-1:0]    WriteData;
    logic [ADDR_W-1:0]    rs1_addr;
    logic [ADDR_W-1:0]    rs2_addr;
    logic                 fwd1_hit;
    logic [DATA_W-1:0]    fwd1_data;
    logic                 fwd2_hit;
    logic [DATA_W-1:0]    fwd2_data;
    logic [2**ADDR_W-1:0] busy;
    modport master (
        output ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data, wb_stall, rs1_addr, rs2_addr,
        input  ld_ready, alu_ready, RegWrite, WriteRegister, WriteData,
               fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, busy
    );
    modport slave (
        input  ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data, wb_stall, rs1_addr, rs2_addr,
        output ld_ready, alu_ready, RegWrite, WriteRegister, WriteData,
               fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, busy
    );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: in-order write-back FIFO exposing every slot and its valid mask
// clk, rst: clock, async active-high reset
// push/din_rd/din_data: enqueue; pop: dequeue head (caller guarantees legality)
// rd_mem/data_mem/valid: all slots for matching; rd_ptr: head index; count: occupancy 0..DEPTH
module wb_fifo #(
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int ADDR_W = rf_pkg::ADDR_W,
    parameter int DEPTH  = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din_rd,
    input  logic [DATA_W-1:0] din_data,
    output logic [ADDR_W-1:0] rd_mem [DEPTH],
    output logic [DATA_W-1:0] data_mem [DEPTH],
    output logic [DEPTH-1:0]  valid,
    output logic [PW-1:0]     rd_ptr,
    output logic [CW-1:0]     count
);
    logic [PW-1:0] wr_ptr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= din_rd;
            data_mem[wr_ptr] <= din_data;
        end
    end
    // a slot is live when its age relative to the head is below the occupancy
    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++) valid[i] = {1'b0, PW'(i) - rd_ptr} < count;
    end
endmodule

// File: rtl/rf_write_queue.sv
// rf_write_queue: arbitrates ALU/load results into a FIFO and drives the register-file write port
// clk, rst: clock, async active-high reset
// bus.ld_*/alu_*: producer handshakes (load has priority); bus.wb_stall: block dequeue
// bus.RegWrite/WriteRegister/WriteData: registered write port
// bus.rs*_addr/fwd*_hit/fwd*_data: youngest-pending forwarding; bus.busy: pending-write bit per register
module rf_write_queue #(
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int ADDR_W = rf_pkg::ADDR_W,
    parameter int DEPTH  = 4
) (
    input logic clk,
    input logic rst,
    rf_write_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int NUM_REGS = 2 ** ADDR_W;
    logic [ADDR_W-1:0]   rd_mem [DEPTH];
    logic [DATA_W-1:0]   data_mem [DEPTH];
    logic [DEPTH-1:0]    valid;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic                pop, space, push;
    logic [ADDR_W-1:0]   in_rd;
    logic [DATA_W-1:0]   in_data;
    logic                reg_write;
    logic [ADDR_W-1:0]   write_register;
    logic [DATA_W-1:0]   write_data;
    logic [NUM_REGS-1:0] busy_v;
    assign pop           = (count != '0) && !bus.wb_stall;
    assign space         = (count < CW'(DEPTH)) || pop;
    assign bus.ld_ready  = space;
    assign bus.alu_ready = space && !bus.ld_valid;
    assign in_rd         = bus.ld_valid ? bus.ld_rd : bus.alu_rd;
    assign in_data       = bus.ld_valid ? bus.ld_data : bus.alu_data;
    // x0 results complete the handshake but are never stored
    assign push          = space && (bus.ld_valid || bus.alu_valid) && in_rd != '0;
    wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .din_rd(in_rd), .din_data(in_data),
        .rd_mem(rd_mem), .data_mem(data_mem), .valid(valid), .rd_ptr(rd_ptr), .count(count)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write      <= 1'b0;
            write_register <= '0;
            write_data     <= '0;
        end else begin
            reg_write <= pop;
            if (pop) begin
                write_register <= rd_mem[rd_ptr];
                write_data     <= data_mem[rd_ptr];
            end
        end
    end
    assign bus.RegWrite      = reg_write;
    assign bus.WriteRegister = write_register;
    assign bus.WriteData     = write_data;
    // oldest first so younger matches overwrite; the output stage is older than any queued entry
    function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] a);
        logic              hit;
        logic [DATA_W-1:0] data;
        logic [PW-1:0]     idx;
        hit  = reg_write && write_register == a;
        data = write_data;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (valid[idx] && rd_mem[idx] == a) begin
                hit  = 1'b1;
                data = data_mem[idx];
            end
        end
        hit = hit && a != '0;
        return {hit, hit ? data : '0};
    endfunction
    always_comb begin
        {bus.fwd1_hit, bus.fwd1_data} = lookup(bus.rs1_addr);
        {bus.fwd2_hit, bus.fwd2_data} = lookup(bus.rs2_addr);
    end
    always_comb begin
        busy_v = '0;
        if (reg_write) busy_v[write_register] = 1'b1;
        for (int k = 0; k < DEPTH; k++) if (valid[k]) busy_v[rd_mem[k]] = 1'b1;
        busy_v[0] = 1'b0;
    end
    assign bus.busy = busy_v;
endmodule

// File: tb/tb_rf_write_queue.sv
// tb_rf_write_queue: table vectors plus directed sequences, scoreboard on the write port
module tb_rf_write_queue;
    import rf_pkg::*;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    rf_write_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();
    rf_write_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    int total = 0;
    int bad = 0;
    wb_entry_t sb[$];
    typedef struct {
        logic              ld_v;
        logic [ADDR_W-1:0] ld_rd;
        logic [DATA_W-1:0] ld_d;
        logic              alu_v;
        logic [ADDR_W-1:0] alu_rd;
        logic [DATA_W-1:0] alu_d;
        logic              exp_ld_rdy;
        logic              exp_alu_rdy;
    } vec_t;
    vec_t vecs[8];
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask
    // records this cycle's accepted enqueue, then advances to the next negedge and checks the write port
    task automatic tick();
        wb_entry_t e;
        #1;
        if (!rst) begin
            if (bus.ld_valid && bus.ld_ready && bus.ld_rd != 0) sb.push_back('{rd: bus.ld_rd, data: bus.ld_data});
            else if (!bus.ld_valid && bus.alu_valid && bus.alu_ready && bus.alu_rd != 0)
                sb.push_back('{rd: bus.alu_rd, data: bus.alu_data});
        end
        @(negedge clk);
        if (bus.RegWrite) begin
            if (sb.size() == 0) chk("stale_write", {63'b0, bus.RegWrite}, 64'd0);
            else begin
                e = sb.pop_front();
                chk("wr_reg", bus.WriteRegister, e.rd);
                chk("wr_data", bus.WriteData, e.data);
            end
        end
    endtask
    task automatic set_alu(input logic v, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
        bus.alu_valid = v;
        bus.alu_rd    = rd;
        bus.alu_data  = d;
    endtask
    task automatic set_ld(input logic v, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
        bus.ld_valid = v;
        bus.ld_rd    = rd;
        bus.ld_data  = d;
    endtask
    task automatic drain();
        set_ld(0, 0, 0);
        set_alu(0, 0, 0);
        bus.wb_stall = 0;
        repeat (6) tick();
    endtask
    initial begin
        vecs[0] = '{1, 3, 32'h11, 0, 0, 0, 1, 0};
        vecs[1] = '{0, 0, 0, 1, 4, 32'h22, 1, 1};
        vecs[2] = '{1, 9, 32'h99, 1, 10, 32'hAA, 1, 0};
        vecs[3] = '{0, 0, 0, 0, 0, 0, 1, 1};
        vecs[4] = '{1, 0, 32'h55, 0, 0, 0, 1, 0};
        vecs[5] = '{0, 0, 0, 1, 31, 32'hFFFF_FFFF, 1, 1};
        vecs[6] = '{1, 31, 32'h1234_5678, 1, 0, 32'h77, 1, 0};
        vecs[7] = '{0, 0, 0, 1, 1, 32'h1, 1, 1};
        rst = 1;
        set_ld(0, 0, 0);
        set_alu(0, 0, 0);
        bus.wb_stall = 0;
        bus.rs1_addr = 5;
        bus.rs2_addr = 5;
        #2;
        chk("rst_regwrite", {63'b0, bus.RegWrite}, 0);
        chk("rst_wreg", bus.WriteRegister, 0);
        chk("rst_wdata", bus.WriteData, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_fwd1", {63'b0, bus.fwd1_hit}, 0);
        chk("rst_fwd2", {63'b0, bus.fwd2_hit}, 0);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            set_ld(vecs[i].ld_v, vecs[i].ld_rd, vecs[i].ld_d);
            set_alu(vecs[i].alu_v, vecs[i].alu_rd, vecs[i].alu_d);
            #1;
            chk($sformatf("vec%0d_ld_ready", i), {63'b0, bus.ld_ready}, {63'b0, vecs[i].exp_ld_rdy});
            chk($sformatf("vec%0d_alu_ready", i), {63'b0, bus.alu_ready}, {63'b0, vecs[i].exp_alu_rdy});
            tick();
        end
        drain();
        bus.rs1_addr = 5;
        set_alu(1, 5, 32'hDEAD_BEEF);
        tick();
        set_alu(0, 0, 0);
        chk("single_busy_q", {63'b0, bus.busy[5]}, 1);
        chk("single_fwd_q", {31'b0, bus.fwd1_hit, bus.fwd1_data}, {31'b0, 1'b1, 32'hDEAD_BEEF});
        chk("single_nowrite_yet", {63'b0, bus.RegWrite}, 0);
        tick();
        chk("single_regwrite", {63'b0, bus.RegWrite}, 1);
        chk("single_wreg", bus.WriteRegister, 5);
        chk("single_busy_out", {63'b0, bus.busy[5]}, 1);
        chk("single_fwd_out", {63'b0, bus.fwd1_hit}, 1);
        tick();
        chk("single_one_pulse", {63'b0, bus.RegWrite}, 0);
        chk("single_busy_clr", bus.busy, 0);
        drain();
        set_ld(1, 3, 32'h11);
        set_alu(1, 4, 32'h22);
        #1;
        chk("cont_ld_ready", {63'b0, bus.ld_ready}, 1);
        chk("cont_alu_ready", {63'b0, bus.alu_ready}, 0);
        tick();
        set_ld(0, 0, 0);
        #1;
        chk("cont_alu_ready2", {63'b0, bus.alu_ready}, 1);
        tick();
        set_alu(0, 0, 0);
        chk("cont_first", {59'b0, bus.RegWrite, bus.WriteRegister}, {59'b0, 1'b1, 5'd3});
        tick();
        chk("cont_second", {59'b0, bus.RegWrite, bus.WriteRegister}, {59'b0, 1'b1, 5'd4});
        drain();
        bus.wb_stall = 1;
        for (int i = 0; i < 4; i++) begin
            set_alu(1, 5'(10 + i), 32'h100 + 32'(i));
            #1;
            chk($sformatf("full_acc%0d", i), {63'b0, bus.alu_ready}, 1);
            tick();
        end
        set_alu(1, 14, 32'h104);
        #1;
        chk("full_5th_blocked", {63'b0, bus.alu_ready}, 0);
        tick();
        chk("full_still_blocked", {63'b0, bus.alu_ready}, 0);
        chk("full_no_write", {63'b0, bus.RegWrite}, 0);
        bus.wb_stall = 0;
        #1;
        chk("full_push_on_pop", {63'b0, bus.alu_ready}, 1);
        tick();
        set_alu(0, 0, 0);
        chk("full_out0", {63'b0, bus.RegWrite}, 1);
        for (int i = 1; i < 5; i++) begin
            tick();
            chk($sformatf("full_out%0d", i), {59'b0, bus.RegWrite, bus.WriteRegister}, {59'b0, 1'b1, 5'(10 + i)});
        end
        tick();
        chk("full_done", {63'b0, bus.RegWrite}, 0);
        drain();
        bus.wb_stall = 1;
        set_alu(1, 7, 32'hA);
        tick();
        set_alu(1, 7, 32'hB);
        tick();
        set_alu(0, 0, 0);
        bus.rs1_addr = 7;
        bus.rs2_addr = 7;
        #1;
        chk("dup_fwd1", {31'b0, bus.fwd1_hit, bus.fwd1_data}, {31'b0, 1'b1, 32'hB});
        chk("dup_fwd2", {31'b0, bus.fwd2_hit, bus.fwd2_data}, {31'b0, 1'b1, 32'hB});
        chk("dup_busy", {63'b0, bus.busy[7]}, 1);
        bus.wb_stall = 0;
        tick();
        chk("dup_pop1_fwd", {31'b0, bus.fwd1_hit, bus.fwd1_data}, {31'b0, 1'b1, 32'hB});
        tick();
        chk("dup_pop2_fwd", {31'b0, bus.fwd1_hit, bus.fwd1_data}, {31'b0, 1'b1, 32'hB});
        tick();
        chk("dup_idle_hit", {63'b0, bus.fwd1_hit}, 0);
        chk("dup_idle_busy", {63'b0, bus.busy[7]}, 0);
        drain();
        bus.rs2_addr = 0;
        set_alu(1, 0, 32'hFFFF);
        #1;
        chk("x0_ready", {63'b0, bus.alu_ready}, 1);
        tick();
        set_alu(0, 0, 0);
        chk("x0_busy", bus.busy, 0);
        chk("x0_fwd2", {63'b0, bus.fwd2_hit}, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("x0_nowrite%0d", i), {63'b0, bus.RegWrite}, 0);
        end
        drain();
        bus.wb_stall = 1;
        bus.rs1_addr = 2;
        for (int i = 1; i <= 4; i++) begin
            set_alu(1, 5'(i), 32'h200 + 32'(i));
            tick();
        end
        set_alu(0, 0, 0);
        bus.wb_stall = 0;
        tick();
        chk("mid_regwrite", {63'b0, bus.RegWrite}, 1);
        bus.wb_stall = 1;
        #2;
        rst = 1;
        #1;
        chk("mid_rst_regwrite", {63'b0, bus.RegWrite}, 0);
        chk("mid_rst_wreg", bus.WriteRegister, 0);
        chk("mid_rst_wdata", bus.WriteData, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_fwd1", {63'b0, bus.fwd1_hit}, 0);
        sb.delete();
        tick();
        rst = 0;
        bus.wb_stall = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("mid_no_stale%0d", i), {63'b0, bus.RegWrite}, 0);
        end
        chk("sb_empty", 64'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rf_write_queue.md
Name: rf_write_queue

Overview:
Producer side of the register-file write port. Accepts write-back results from the ALU and load unit, buffers them in a small in-order FIFO, and drives the register file's RegWrite/WriteRegister/WriteData port at one write per cycle. Also exposes a pending-write scoreboard and a forwarding lookup, so decode can stall or bypass on registers that are still queued.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 5, register index width (2**ADDR_W registers)
DEPTH, 4, FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous, active-high reset
ld_valid  in  1  load result valid
ld_rd  in  ADDR_W  load destination register
ld_data  in  DATA_W  load result
ld_ready  out  1  load result accepted this cycle when ld_valid&ld_ready
alu_valid  in  1  ALU result valid
alu_rd  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
alu_ready  out  1  ALU result accepted when alu_valid&alu_ready
wb_stall  in  1  block dequeue this cycle
RegWrite  out  1  register-file write enable (registered)
WriteRegister  out  ADDR_W  register-file write index (registered)
WriteData  out  DATA_W  register-file write data (registered)
rs1_addr  in  ADDR_W  forwarding lookup 1
rs2_addr  in  ADDR_W  forwarding lookup 2
fwd1_hit  out  1  rs1 has a pending write
fwd1_data  out  DATA_W  youngest pending data for rs1
fwd2_hit  out  1  rs2 has a pending write
fwd2_data  out  DATA_W  youngest pending data for rs2
busy  out  2**ADDR_W  per-register pending-write bit vector

Behaviour:
- Reset (async, any time): count=0, rd/wr pointers=0, RegWrite=0, WriteRegister=0, WriteData=0, busy=0, fwd hits=0. Queued writes are discarded.
- pop = (count!=0) & !wb_stall.
- space = (count<DEPTH) | pop.
- Arbitration: at most one enqueue per cycle. Load has fixed priority.
  - ld_ready = space.
  - alu_ready = space & !ld_valid.
- Enqueue with rd==0 is handshaken (ready high) but not stored. No entry, no write, no busy change.
- Output stage, every posedge:
  - If pop: RegWrite<=1, WriteRegister/WriteData<=head entry, rd_ptr advances.
  - Else: RegWrite<=0; WriteRegister/WriteData hold their previous values.
  - The register file commits on the following negedge.
- Latency: entry accepted at posedge k appears on RegWrite in the cycle after posedge k+1 (no stall). Dequeue throughput is 1 per cycle.
- Simultaneous push and pop: count unchanged. When full with pop, a push is legal.
- Ordering: strict FIFO order. Two queued writes to the same rd both reach the register file, oldest first.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH and is never exceeded. Ready low means the producer holds its data stable.
- Forwarding/busy: combinational match of lookup addresses against valid FIFO entries plus the output stage while RegWrite=1.
  - Priority, youngest wins: FIFO tail-1 down to head, then output stage.
  - Lookups of x0 never hit. busy[0] is always 0.
  - The output stage remains a hit for its whole cycle, because the register-file write lands at mid-cycle.
- A combinational same-cycle bypass of entries being enqueued is not provided. Decode sees them one cycle later.

Decomposition:
- Shared package rf_pkg: DATA_W/ADDR_W defaults, NUM_REGS = 2**ADDR_W, and a wb_entry_t struct {rd, data}.
- One natural sub-module: wb_fifo (storage, pointers, count, push/pop, exposes all entries and valid mask for matching).
- Arbitration, output register, and forwarding/busy logic live in rf_write_queue.

Test Plan:
- Single ALU write: alu rd=5, data=0xDEADBEEF, one cycle.
  - RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF exactly one cycle, two posedges after acceptance.
  - busy[5]=1 from acceptance through the end of the RegWrite cycle.
- Contention: ld (rd=3, 0x11) and alu (rd=4, 0x22) valid together.
  - ld_ready=1, alu_ready=0.
  - Writes appear as rd3=0x11, then rd4=0x22 on consecutive RegWrite cycles.
- Full/stall: hold wb_stall=1, push 5 ALU writes.
  - First 4 are accepted; alu_ready=0 on the 5th.
  - Release stall: 5 writes emerge in order on 5 consecutive cycles; the 5th is accepted once the first pop occurs.
- Forwarding with duplicates: queue rd=7 data 0xA, then rd=7 data 0xB, with stall held.
  - rs1_addr=7 gives fwd1_hit=1, fwd1_data=0xB.
  - After both pops and one idle cycle, fwd1_hit=0 and busy[7]=0.
- x0 discard: alu rd=0, data=0xFFFF.
  - alu_ready=1, but no RegWrite pulse, busy stays 0, and rs2_addr=0 gives fwd2_hit=0.
- Reset mid-operation: 3 entries queued and RegWrite=1; assert rst asynchronously between edges.
  - Outputs go to 0 immediately, busy=0.
  - After release, no stale writes occur.
